tc_sram_banked: RTL and testbench

TC_SRAM_BANKED -- requirements
Module: tc_sram_banked

---
 rtl/tc_sram_banked.sv | 213 +++++++++++++++++++++
 tb/tb_tc_sram_banked.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tc_sram_banked.sv
// Multi-port, word-interleaved banked SRAM with per-bank round-robin arbitration and a pipelined read path.
// Define TC_SRAM_BANKED_CONFLICT_CNT_EN to enable the saturating bank-conflict counter on conflict_cnt_o.
module tc_sram_banked #(
   parameter int unsigned  NumWords  = 1024,
   parameter int unsigned  DataWidth = 32,
   parameter int unsigned  ByteWidth = 8,
   parameter int unsigned  NumPorts  = 4,
   parameter int unsigned  NumBanks  = 4,
   parameter int unsigned  Latency   = 1,
   parameter string        SimInit   = "none",
   localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
   localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NumPorts-1:0]             req_i,
   output logic [NumPorts-1:0]             gnt_o,
   input  logic [NumPorts-1:0]             we_i,
   input  logic [NumPorts*AddrWidth-1:0]   addr_i,
   input  logic [NumPorts*DataWidth-1:0]   wdata_i,
   input  logic [NumPorts*BeWidth-1:0]     be_i,
   output logic [NumPorts-1:0]             rvalid_o,
   output logic [NumPorts*DataWidth-1:0]   rdata_o,
   output logic [31:0]                     conflict_cnt_o
);

   localparam int unsigned BankSel      = (NumBanks > 1) ? $clog2(NumBanks) : 0;
   localparam int unsigned BankW        = (BankSel > 0) ? BankSel : 1;
   localparam int unsigned RowWidth     = (AddrWidth > BankSel) ? AddrWidth - BankSel : 1;
   localparam int unsigned WordsPerBank = NumWords / NumBanks;
   localparam int unsigned PortW        = (NumPorts > 1) ? $clog2(NumPorts) : 1;

   // Content loaded into word idx at reset; "random" is a fixed scrambled pattern.
   function automatic logic [DataWidth-1:0] init_word(input int unsigned idx);
      if (SimInit == "ones")   return '1;
      if (SimInit == "random") return DataWidth'(idx * 32'h9E37_79B9 + 32'h7F4A_7C15);
      return '0;
   endfunction

   localparam logic [DataWidth-1:0] RstData = init_word(0);

   logic [AddrWidth-1:0] addr     [NumPorts];
   logic [BankW-1:0]     bank     [NumPorts];
   logic [RowWidth-1:0]  row      [NumPorts];
   logic [NumPorts-1:0]  in_range;
   logic [DataWidth-1:0] rd_word  [NumPorts];
   logic [NumPorts-1:0]  gnt;
   logic [NumPorts-1:0]  rd_gnt;

   logic [NumBanks-1:0]  bank_vld;
   logic [PortW-1:0]     bank_port [NumBanks];
   logic [PortW-1:0]     rr_ptr_q  [NumBanks];
   logic [PortW-1:0]     rr_ptr_d  [NumBanks];

   logic [NumBanks-1:0]  wr_en;
   logic [RowWidth-1:0]  wr_row    [NumBanks];
   logic [DataWidth-1:0] wr_data   [NumBanks];
   logic [DataWidth-1:0] wr_old;
   logic [DataWidth-1:0] wr_wdat;
   logic [BeWidth-1:0]   wr_be;
   int unsigned          wp;

   logic [DataWidth-1:0] mem_q     [NumBanks][WordsPerBank];
   logic [Latency-1:0]   vld_q     [NumPorts];
   logic [DataWidth-1:0] dat_q     [NumPorts][Latency];

   for (genvar p = 0; p < NumPorts; p++) begin : g_addr
      assign addr[p]     = addr_i[p*AddrWidth +: AddrWidth];
      assign in_range[p] = ({1'b0, addr[p]} < (AddrWidth + 1)'(NumWords));
      if (BankSel == 0) begin : g_one_bank
         assign bank[p] = '0;
         assign row[p]  = addr[p];
      end else if (AddrWidth > BankSel) begin : g_multi_bank
         assign bank[p] = addr[p][BankSel-1:0];
         assign row[p]  = addr[p][AddrWidth-1:BankSel];
      end else begin : g_one_row
         assign bank[p] = addr[p][BankW-1:0];
         assign row[p]  = '0;
      end
   end

   // Per bank: first candidate at or above rr_ptr, otherwise wrap to the lowest candidate.
   always_comb begin
      gnt      = '0;
      bank_vld = '0;
      for (int b = 0; b < NumBanks; b++) begin
         bank_port[b] = '0;
         for (int p = 0; p < NumPorts; p++) begin
            if (!bank_vld[b] && req_i[p] && (bank[p] == BankW'(b)) && (p >= int'(rr_ptr_q[b]))) begin
               bank_vld[b]  = 1'b1;
               bank_port[b] = PortW'(p);
            end
         end
         for (int p = 0; p < NumPorts; p++) begin
            if (!bank_vld[b] && req_i[p] && (bank[p] == BankW'(b))) begin
               bank_vld[b]  = 1'b1;
               bank_port[b] = PortW'(p);
            end
         end
         rr_ptr_d[b] = (bank_port[b] == PortW'(NumPorts - 1)) ? '0 : bank_port[b] + 1'b1;
         if (bank_vld[b]) gnt[bank_port[b]] = 1'b1;
      end
   end

   assign gnt_o  = gnt;
   assign rd_gnt = gnt & ~we_i;

   // Byte-merged write word for each bank, built from the granted port.
   always_comb begin
      wp      = 0;
      wr_old  = '0;
      wr_wdat = '0;
      wr_be   = '0;
      for (int b = 0; b < NumBanks; b++) begin
         wr_en[b]   = 1'b0;
         wr_row[b]  = '0;
         wr_data[b] = '0;
         if (bank_vld[b]) begin
            wp         = int'(bank_port[b]);
            wr_en[b]   = we_i[wp] && in_range[wp];
            wr_row[b]  = row[wp];
            wr_old     = mem_q[b][row[wp]];
            wr_wdat    = wdata_i[wp*DataWidth +: DataWidth];
            wr_be      = be_i[wp*BeWidth +: BeWidth];
            for (int i = 0; i < DataWidth; i++) begin
               wr_data[b][i] = wr_be[i/ByteWidth] ? wr_wdat[i] : wr_old[i];
            end
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         rd_word[p] = in_range[p] ? mem_q[bank[p]][row[p]] : 'x;
      end
   end

   if (SimInit == "none") begin : g_mem_noinit
      always_ff @(posedge clk_i) begin
         for (int b = 0; b < NumBanks; b++) begin
            if (wr_en[b]) mem_q[b][wr_row[b]] <= wr_data[b];
         end
      end
   end else begin : g_mem_init
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int b = 0; b < NumBanks; b++) begin
               for (int w = 0; w < WordsPerBank; w++) begin
                  mem_q[b][w] <= init_word(w * NumBanks + b);
               end
            end
         end else begin
            for (int b = 0; b < NumBanks; b++) begin
               if (wr_en[b]) mem_q[b][wr_row[b]] <= wr_data[b];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int b = 0; b < NumBanks; b++) rr_ptr_q[b] <= '0;
      end else begin
         for (int b = 0; b < NumBanks; b++) begin
            if (bank_vld[b]) rr_ptr_q[b] <= rr_ptr_d[b];
         end
      end
   end

   // Each stage only loads data when its input is valid, so the last stage holds the last read.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int p = 0; p < NumPorts; p++) begin
            vld_q[p] <= '0;
            for (int k = 0; k < Latency; k++) dat_q[p][k] <= RstData;
         end
      end else begin
         for (int p = 0; p < NumPorts; p++) begin
            vld_q[p][0] <= rd_gnt[p];
            if (rd_gnt[p]) dat_q[p][0] <= rd_word[p];
            for (int k = 1; k < Latency; k++) begin
               vld_q[p][k] <= vld_q[p][k-1];
               if (vld_q[p][k-1]) dat_q[p][k] <= dat_q[p][k-1];
            end
         end
      end
   end

   for (genvar p = 0; p < NumPorts; p++) begin : g_out
      assign rvalid_o[p]                        = vld_q[p][Latency-1];
      assign rdata_o[p*DataWidth +: DataWidth] = dat_q[p][Latency-1];
   end

`ifdef TC_SRAM_BANKED_CONFLICT_CNT_EN
   logic [31:0] conflict_cnt_q;
   logic        conflict;

   assign conflict = |(req_i & ~gnt);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         conflict_cnt_q <= '0;
      end else if (conflict && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
         conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
   end

   assign conflict_cnt_o = conflict_cnt_q;
`else
   assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tc_sram_banked.sv
// Directed bench for tc_sram_banked: 2 ports, 2 banks, read latency 2, zero-initialised array.
module tb_tc_sram_banked;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [7:0]  addr;
   logic [63:0] wdata;
   logic [7:0]  be;
   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [63:0] rdata;
   logic [31:0] cnt;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_cnt  = 32'd0;

   tc_sram_banked #(
      .NumWords (16),
      .DataWidth(32),
      .ByteWidth(8),
      .NumPorts (2),
      .NumBanks (2),
      .Latency  (2),
      .SimInit  ("zeros")
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .req_i         (req),
      .gnt_o         (gnt),
      .we_i          (we),
      .addr_i        (addr),
      .wdata_i       (wdata),
      .be_i          (be),
      .rvalid_o      (rvalid),
      .rdata_o       (rdata),
      .conflict_cnt_o(cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic r, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] b);
      req[p]           = r;
      we[p]            = w;
      addr[p*4 +: 4]   = a;
      wdata[p*32 +: 32] = d;
      be[p*4 +: 4]     = b;
   endtask

   task automatic idle();
      req = 2'b00;
      we  = 2'b00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      addr = '0; wdata = '0; be = '0;
      step(); step(); step();
      n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b expected %b", rvalid, 2'b00); end
      n_checks++; if (rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected %h", rdata, 64'd0); end
      n_checks++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_conflict();
      logic [1:0] exp_g [4];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      drive(0, 1'b1, 1'b0, 4'd2, 32'd0, 4'h0);
      drive(1, 1'b1, 1'b0, 4'd6, 32'd0, 4'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (gnt !== exp_g[i]) begin n_fail++; $display("FAIL conflict_gnt%0d: got %b expected %b", i, gnt, exp_g[i]); end
         step();
      end
      idle();
`ifdef TC_SRAM_BANKED_CONFLICT_CNT_EN
      exp_cnt = exp_cnt + 32'd4;
`endif
      n_checks++; if (cnt !== exp_cnt) begin n_fail++; $display("FAIL conflict_cnt: got %0d expected %0d", cnt, exp_cnt); end
      step(); step(); step();
   endtask

   task automatic test_write_read();
      drive(0, 1'b1, 1'b1, 4'd4, 32'hDEAD_BEEF, 4'hF);
      #1;
      n_checks++; if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b expected 1", gnt[0]); end
      step();
      drive(0, 1'b1, 1'b0, 4'd4, 32'd0, 4'h0);
      #1;
      n_checks++; if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b expected 1", gnt[0]); end
      step();
      idle();
      n_checks++; if (rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL rd_early_rvalid: got %b expected 0", rvalid[0]); end
      step();
      n_checks++; if (rvalid[0] !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid: got %b expected 1", rvalid[0]); end
      n_checks++; if (rdata[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h expected %h", rdata[31:0], 32'hDEAD_BEEF); end
      step();
      n_checks++; if (rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL rd_pulse_end: got %b expected 0", rvalid[0]); end
      n_checks++; if (rdata[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_hold: got %h expected %h", rdata[31:0], 32'hDEAD_BEEF); end
   endtask

   task automatic test_byte_enable();
      drive(0, 1'b1, 1'b1, 4'd3, 32'h1122_3344, 4'hF);
      step();
      drive(0, 1'b1, 1'b1, 4'd3, 32'hAABB_CCDD, 4'h2);
      step();
      drive(0, 1'b1, 1'b0, 4'd3, 32'd0, 4'h0);
      step();
      idle();
      step();
      n_checks++; if (rvalid[0] !== 1'b1) begin n_fail++; $display("FAIL be_rvalid: got %b expected 1", rvalid[0]); end
      n_checks++; if (rdata[31:0] !== 32'h1122_CC44) begin n_fail++; $display("FAIL be_data: got %h expected %h", rdata[31:0], 32'h1122_CC44); end
      drive(0, 1'b1, 1'b1, 4'd3, 32'h5566_7788, 4'h9);
      step();
      drive(0, 1'b1, 1'b0, 4'd3, 32'd0, 4'h0);
      step();
      idle();
      step();
      n_checks++; if (rdata[31:0] !== 32'h5522_CC88) begin n_fail++; $display("FAIL be_data2: got %h expected %h", rdata[31:0], 32'h5522_CC88); end
      step();
   endtask

   task automatic test_parallel();
      drive(0, 1'b1, 1'b1, 4'd0, 32'hA0A0_A0A0, 4'hF);
      drive(1, 1'b1, 1'b1, 4'd1, 32'hB1B1_B1B1, 4'hF);
      #1;
      n_checks++; if (gnt !== 2'b11) begin n_fail++; $display("FAIL par_wr_gnt: got %b expected %b", gnt, 2'b11); end
      step();
      drive(0, 1'b1, 1'b0, 4'd0, 32'd0, 4'h0);
      drive(1, 1'b1, 1'b0, 4'd1, 32'd0, 4'h0);
      #1;
      n_checks++; if (gnt !== 2'b11) begin n_fail++; $display("FAIL par_rd_gnt: got %b expected %b", gnt, 2'b11); end
      step();
      idle();
      n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL par_early: got %b expected %b", rvalid, 2'b00); end
      step();
      n_checks++; if (rvalid !== 2'b11) begin n_fail++; $display("FAIL par_rvalid: got %b expected %b", rvalid, 2'b11); end
      n_checks++; if (rdata !== 64'hB1B1_B1B1_A0A0_A0A0) begin n_fail++; $display("FAIL par_data: got %h expected %h", rdata, 64'hB1B1_B1B1_A0A0_A0A0); end
      n_checks++; if (cnt !== exp_cnt) begin n_fail++; $display("FAIL par_cnt: got %0d expected %0d", cnt, exp_cnt); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] d [4];
      for (int i = 0; i < 4; i++) d[i] = 32'hC0DE_0000 | 32'(i * 17);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, 1'b1, 4'(8 + i), d[i], 4'hF);
         step();
      end
      for (int i = 0; i < 7; i++) begin
         if (i < 4) drive(0, 1'b1, 1'b0, 4'(8 + i), 32'd0, 4'h0);
         else idle();
         if (i >= 2 && i < 6) begin
            n_checks++; if (rvalid[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid%0d: got %b expected 1", i, rvalid[0]); end
            n_checks++; if (rdata[31:0] !== d[i-2]) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", i, rdata[31:0], d[i-2]); end
         end else begin
            n_checks++; if (rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_idle%0d: got %b expected 0", i, rvalid[0]); end
         end
         step();
      end
   endtask

   task automatic test_reset_inflight();
      drive(0, 1'b1, 1'b0, 4'd4, 32'd0, 4'h0);
      #1;
      n_checks++; if (gnt[0] !== 1'b1) begin n_fail++; $display("FAIL inflight_gnt: got %b expected 1", gnt[0]); end
      step();
      idle();
      rst_n = 1'b0;
      #1;
      exp_cnt = 32'd0;
      n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL inflight_rvalid0: got %b expected %b", rvalid, 2'b00); end
      n_checks++; if (cnt !== exp_cnt) begin n_fail++; $display("FAIL inflight_cnt: got %0d expected 0", cnt); end
      n_checks++; if (rdata !== 64'd0) begin n_fail++; $display("FAIL inflight_rdata: got %h expected 0", rdata); end
      step();
      n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL inflight_rvalid1: got %b expected %b", rvalid, 2'b00); end
      step();
      n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL inflight_rvalid2: got %b expected %b", rvalid, 2'b00); end
      rst_n = 1'b1;
      step();
      drive(0, 1'b1, 1'b0, 4'd4, 32'd0, 4'h0);
      drive(1, 1'b1, 1'b0, 4'd6, 32'd0, 4'h0);
      #1;
      n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL post_rst_gnt0: got %b expected %b", gnt, 2'b01); end
      step();
      req[0] = 1'b0;
      #1;
      n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL post_rst_gnt1: got %b expected %b", gnt, 2'b10); end
      step();
      idle();
`ifdef TC_SRAM_BANKED_CONFLICT_CNT_EN
      exp_cnt = 32'd1;
`endif
      n_checks++; if (cnt !== exp_cnt) begin n_fail++; $display("FAIL post_rst_cnt: got %0d expected %0d", cnt, exp_cnt); end
      n_checks++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL post_rst_rv0: got %b expected %b", rvalid, 2'b01); end
      n_checks++; if (rdata[31:0] !== 32'd0) begin n_fail++; $display("FAIL post_rst_reinit: got %h expected 0", rdata[31:0]); end
      step();
      n_checks++; if (rvalid !== 2'b10) begin n_fail++; $display("FAIL post_rst_rv1: got %b expected %b", rvalid, 2'b10); end
      step();
   endtask

   initial begin
      test_reset();
      test_conflict();
      test_write_read();
      test_byte_enable();
      test_parallel();
      test_back_to_back();
      test_reset_inflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
